// File: rtl/controlador_irrigacao_if.sv
// Sensor, tick and actuator/display signals of the irrigation controller.
interface controlador_irrigacao_if;
   logic       tick;
   logic       H, M, L;
   logic       Us, Ua, T;
   logic       Vs, Bs, Ve;
   logic       erro, alarme, ocupado;
   logic [3:0] seg_u, seg_d, min_u, min_d;

   modport master (
      output tick, H, M, L, Us, Ua, T,
      input  Vs, Bs, Ve, erro, alarme, ocupado, seg_u, seg_d, min_u, min_d
   );

   modport slave (
      input  tick, H, M, L, Us, Ua, T,
      output Vs, Bs, Ve, erro, alarme, ocupado, seg_u, seg_d, min_u, min_d
   );
endinterface

// File: rtl/controlador_irrigacao.sv
// Irrigation session controller: timed sprinkler/drip sessions, rest period,
// tank refill with hysteresis, latched sensor fault and mm:ss BCD elapsed time.
module controlador_irrigacao #(
   parameter int unsigned T_ASP   = 120,
   parameter int unsigned T_GOT   = 300,
   parameter int unsigned T_PAUSA = 60
) (
   input logic                    clk,
   input logic                    reset,
   controlador_irrigacao_if.slave bus
);

   localparam int unsigned CW = 12;
   localparam logic [CW-1:0] DUR_ASP   = CW'(T_ASP);
   localparam logic [CW-1:0] DUR_GOT   = CW'(T_GOT);
   localparam logic [CW-1:0] DUR_PAUSA = CW'(T_PAUSA);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      ASPERSAO = 3'd1,
      GOTEJO   = 3'd2,
      PAUSA    = 3'd3,
      ERRO     = 3'd4
   } estado_t;

   estado_t       estado;
   logic [CW-1:0] decorrido, duracao, repouso;
   logic          vazio, baixo, medio, cheio, falha;
   logic [3:0]    su_n, sd_n, mu_n, md_n;

   // Tank level decode; any non-thermometer code is a sensor fault
   always_comb begin
      vazio = ({bus.H, bus.M, bus.L} == 3'b000);
      baixo = ({bus.H, bus.M, bus.L} == 3'b001);
      medio = ({bus.H, bus.M, bus.L} == 3'b011);
      cheio = ({bus.H, bus.M, bus.L} == 3'b111);
      falha = ~(vazio | baixo | medio | cheio);
   end

   // Next mm:ss value with BCD carries, 59:59 wraps to 00:00
   always_comb begin
      su_n = bus.seg_u + 4'd1;
      sd_n = bus.seg_d;
      mu_n = bus.min_u;
      md_n = bus.min_d;
      if (bus.seg_u == 4'd9) begin
         su_n = 4'd0;
         sd_n = bus.seg_d + 4'd1;
         if (bus.seg_d == 4'd5) begin
            sd_n = 4'd0;
            mu_n = bus.min_u + 4'd1;
            if (bus.min_u == 4'd9) begin
               mu_n = 4'd0;
               md_n = (bus.min_d == 4'd5) ? 4'd0 : bus.min_d + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado      <= OCIOSO;
         decorrido   <= '0;
         duracao     <= '0;
         repouso     <= '0;
         bus.Vs      <= 1'b0;
         bus.Bs      <= 1'b0;
         bus.Ve      <= 1'b0;
         bus.erro    <= 1'b0;
         bus.alarme  <= 1'b0;
         bus.ocupado <= 1'b0;
         bus.seg_u   <= 4'd0;
         bus.seg_d   <= 4'd0;
         bus.min_u   <= 4'd0;
         bus.min_d   <= 4'd0;
      end else begin
         if (estado != ERRO && falha) begin
            estado      <= ERRO;
            bus.Vs      <= 1'b0;
            bus.Bs      <= 1'b0;
            bus.ocupado <= 1'b0;
            bus.erro    <= 1'b1;
         end else begin
            case (estado)
               OCIOSO: begin
                  // Method and duration are frozen here for the whole session
                  if (bus.Us && !vazio) begin
                     bus.ocupado <= 1'b1;
                     decorrido   <= '0;
                     bus.seg_u   <= 4'd0;
                     bus.seg_d   <= 4'd0;
                     bus.min_u   <= 4'd0;
                     bus.min_d   <= 4'd0;
                     if (bus.Ua || bus.T) begin
                        estado  <= GOTEJO;
                        bus.Bs  <= 1'b1;
                        duracao <= DUR_GOT;
                     end else begin
                        estado  <= ASPERSAO;
                        bus.Vs  <= 1'b1;
                        duracao <= DUR_ASP;
                     end
                  end
               end
               ASPERSAO, GOTEJO: begin
                  if (bus.tick) begin
                     decorrido <= decorrido + CW'(1);
                     bus.seg_u <= su_n;
                     bus.seg_d <= sd_n;
                     bus.min_u <= mu_n;
                     bus.min_d <= md_n;
                  end
                  if (vazio || !bus.Us ||
                      (bus.tick && (decorrido + CW'(1) == duracao))) begin
                     estado  <= PAUSA;
                     bus.Vs  <= 1'b0;
                     bus.Bs  <= 1'b0;
                     repouso <= '0;
                  end
               end
               PAUSA: begin
                  if (bus.tick) begin
                     if (repouso + CW'(1) == DUR_PAUSA) begin
                        estado      <= OCIOSO;
                        bus.ocupado <= 1'b0;
                     end else begin
                        repouso <= repouso + CW'(1);
                     end
                  end
               end
               ERRO: begin
               end
               default: estado <= OCIOSO;
            endcase
         end

         // Refill hysteresis: open at empty/low, close only at full
         if (estado == ERRO || falha) begin
            bus.Ve     <= 1'b0;
            bus.alarme <= 1'b0;
         end else begin
            bus.alarme <= vazio;
            if (vazio || baixo) bus.Ve <= 1'b1;
            else if (cheio)     bus.Ve <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_controlador_irrigacao.sv
// Directed bench for controlador_irrigacao: expected output vectors are queued
// as stimulus is applied and checked after the following clock edge.
module tb_controlador_irrigacao;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   controlador_irrigacao_if if1 ();
   controlador_irrigacao_if if2 ();

   controlador_irrigacao #(.T_ASP(3), .T_GOT(5), .T_PAUSA(2)) dut1 (
      .clk(clk), .reset(reset), .bus(if1)
   );
   controlador_irrigacao #(.T_ASP(3599), .T_GOT(3599), .T_PAUSA(1)) dut2 (
      .clk(clk), .reset(reset), .bus(if2)
   );

   typedef struct {
      int unsigned dut;
      string       tag;
      logic [21:0] exp;
   } item_t;

   item_t sb[$];
   int    total = 0;
   int    bad   = 0;

   // {Vs,Bs,Ve,erro,alarme,ocupado,min_d,min_u,seg_d,seg_u}
   function automatic logic [21:0] ev(input int vs, input int bs, input int ve,
                                      input int er, input int al, input int oc,
                                      input int mm, input int ss);
      return {1'(vs), 1'(bs), 1'(ve), 1'(er), 1'(al), 1'(oc),
              4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [21:0] obs1();
      return {if1.Vs, if1.Bs, if1.Ve, if1.erro, if1.alarme, if1.ocupado,
              if1.min_d, if1.min_u, if1.seg_d, if1.seg_u};
   endfunction

   function automatic logic [21:0] obs2();
      return {if2.Vs, if2.Bs, if2.Ve, if2.erro, if2.alarme, if2.ocupado,
              if2.min_d, if2.min_u, if2.seg_d, if2.seg_u};
   endfunction

   task automatic push(input int unsigned d, input string tag, input logic [21:0] e);
      sb.push_back('{d, tag, e});
   endtask

   // Advance one edge, then drain the scoreboard against the DUT outputs
   task automatic cycle();
      item_t       it;
      logic [21:0] o;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         o  = (it.dut == 1) ? obs1() : obs2();
         total++;
         assert (o === it.exp)
         else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", it.tag, o, it.exp);
         end
      end
   endtask

   task automatic step1(input logic t, input string tag, input logic [21:0] e);
      if1.tick = t;
      push(1, tag, e);
      cycle();
      if1.tick = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         if1.tick = 1'b1;
         cycle();
         if1.tick = 1'b0;
         cycle();
      end
   endtask

   initial begin
      reset = 1'b1;
      if1.tick = 1'b0; {if1.H, if1.M, if1.L} = 3'b111;
      if1.Us = 1'b0; if1.Ua = 1'b0; if1.T = 1'b0;
      if2.tick = 1'b0; {if2.H, if2.M, if2.L} = 3'b111;
      if2.Us = 1'b0; if2.Ua = 1'b0; if2.T = 1'b0;

      push(2, "reset2", ev(0, 0, 0, 0, 0, 0, 0, 0));
      step1(0, "reset", ev(0, 0, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      cycle();

      // Sprinkler session of 3 ticks, rest of 2 ticks, automatic restart
      if1.Us = 1'b1;
      step1(0, "asp_start",  ev(1, 0, 0, 0, 0, 1, 0, 0));
      step1(1, "asp_t1",     ev(1, 0, 0, 0, 0, 1, 0, 1));
      step1(0, "asp_hold",   ev(1, 0, 0, 0, 0, 1, 0, 1));
      step1(1, "asp_t2",     ev(1, 0, 0, 0, 0, 1, 0, 2));
      step1(1, "asp_t3_end", ev(0, 0, 0, 0, 0, 1, 0, 3));
      step1(1, "rest_t1",    ev(0, 0, 0, 0, 0, 1, 0, 3));
      step1(1, "rest_t2",    ev(0, 0, 0, 0, 0, 0, 0, 3));
      step1(0, "restart",    ev(1, 0, 0, 0, 0, 1, 0, 0));
      if1.Us = 1'b0;
      step1(0, "us_drop",    ev(0, 0, 0, 0, 0, 1, 0, 0));
      run_ticks(2);

      // Drip session: T dropped mid-session must not change method or length
      if1.T = 1'b1; if1.Us = 1'b1;
      step1(0, "got_start",  ev(0, 1, 0, 0, 0, 1, 0, 0));
      step1(1, "got_t1",     ev(0, 1, 0, 0, 0, 1, 0, 1));
      step1(1, "got_t2",     ev(0, 1, 0, 0, 0, 1, 0, 2));
      if1.T = 1'b0;
      step1(1, "got_t3",     ev(0, 1, 0, 0, 0, 1, 0, 3));
      step1(1, "got_t4",     ev(0, 1, 0, 0, 0, 1, 0, 4));
      step1(1, "got_t5_end", ev(0, 0, 0, 0, 0, 1, 0, 5));
      if1.Us = 1'b0;
      run_ticks(2);
      step1(0, "idle_hold",  ev(0, 0, 0, 0, 0, 0, 0, 5));

      // Tank empties mid-session, then refills through medium to full
      if1.Ua = 1'b1; if1.Us = 1'b1;
      step1(0, "got2_start", ev(0, 1, 0, 0, 0, 1, 0, 0));
      {if1.H, if1.M, if1.L} = 3'b000;
      step1(0, "empty_exit", ev(0, 0, 1, 0, 1, 1, 0, 0));
      if1.Us = 1'b0; {if1.H, if1.M, if1.L} = 3'b011;
      step1(0, "refill_med", ev(0, 0, 1, 0, 0, 1, 0, 0));
      {if1.H, if1.M, if1.L} = 3'b111;
      step1(0, "refill_full", ev(0, 0, 0, 0, 0, 1, 0, 0));
      if1.Ua = 1'b0;
      run_ticks(2);

      // Sensor fault latches until reset
      if1.Us = 1'b1;
      step1(0, "asp3_start", ev(1, 0, 0, 0, 0, 1, 0, 0));
      step1(1, "asp3_t1",    ev(1, 0, 0, 0, 0, 1, 0, 1));
      {if1.H, if1.M, if1.L} = 3'b101;
      step1(0, "fault",      ev(0, 0, 0, 1, 0, 0, 0, 1));
      {if1.H, if1.M, if1.L} = 3'b111;
      step1(1, "fault_latched", ev(0, 0, 0, 1, 0, 0, 0, 1));
      {if1.H, if1.M, if1.L} = 3'b001;
      step1(0, "fault_ve_off", ev(0, 0, 0, 1, 0, 0, 0, 1));
      if1.Us = 1'b0; reset = 1'b1;
      step1(0, "reset_mid",  ev(0, 0, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      step1(0, "low_ve_on",  ev(0, 0, 1, 0, 0, 0, 0, 0));
      {if1.H, if1.M, if1.L} = 3'b011;
      step1(0, "med_ve_hold", ev(0, 0, 1, 0, 0, 0, 0, 0));
      {if1.H, if1.M, if1.L} = 3'b111;
      step1(0, "full_ve_off", ev(0, 0, 0, 0, 0, 0, 0, 0));

      // Long sprinkler run on the second instance: BCD carries and 59:59 end
      if2.Us = 1'b1;
      push(2, "d2_start", ev(1, 0, 0, 0, 0, 1, 0, 0));
      cycle();
      for (int n = 1; n <= 3599; n++) begin
         if2.tick = 1'b1;
         if (n == 9 || n == 10 || n == 59 || n == 60 || n == 599 || n == 600 ||
             n == 3598 || n == 3599)
            push(2, $sformatf("d2_t%0d", n),
                 ev((n == 3599) ? 0 : 1, 0, 0, 0, 0, 1, n / 60, n % 60));
         cycle();
         if2.tick = 1'b0;
         cycle();
      end
      if2.Us = 1'b0;
      if2.tick = 1'b1;
      push(2, "d2_rest_end", ev(0, 0, 0, 0, 0, 0, 59, 59));
      cycle();
      if2.tick = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controlador_irrigacao.md
# controlador_irrigacao

Irrigation session controller that sequences the sprinkler valve (Vs), drip pump (Bs) and tank inlet valve (Ve) from the tank level sensors (H, M, L), soil/air humidity (Us, Ua) and temperature (T). It runs timed irrigation sessions, enforces a rest period between sessions, manages tank refill with hysteresis, and latches sensor faults. The elapsed session time is driven out as four BCD digits (mm:ss) for the existing 7-segment display path. All timing advances on a 1 Hz enable pulse from the clock divider.

## Interface
- T_ASP, 120: sprinkler session length in seconds (1..3599)
- T_GOT, 300: drip session length in seconds (1..3599)
- T_PAUSA, 60: minimum rest between sessions in seconds (1..3599)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  1 Hz enable, one clk cycle wide
- H, M, L  in  1 each  level sensors (1 = water at sensor), synchronous to clk
- Us  in  1  soil dry (1 = irrigation required)
- Ua  in  1  low air humidity (1 = low)
- T  in  1  high temperature (1 = high)
- Vs  out  1  sprinkler valve
- Bs  out  1  drip pump
- Ve  out  1  tank inlet valve
- erro  out  1  latched sensor fault
- alarme  out  1  tank empty
- ocupado  out  1  session or rest in progress
- seg_u, seg_d, min_u, min_d  out  4 each  elapsed session time, BCD

## Operation
- Level decode of {H,M,L}: 000 empty, 001 low, 011 medium, 111 full; any other code is a fault.
- States: OCIOSO, ASPERSAO, GOTEJO, PAUSA, ERRO.
- OCIOSO: fault -> ERRO. Else if Us=1 and level != empty -> start session: (Ua|T)=1 selects GOTEJO, else ASPERSAO. Method and duration are latched at start; Ua/T changes mid-session are ignored. BCD time and internal second counter clear to 0 on start.
- ASPERSAO/GOTEJO: Vs=1 (ASPERSAO) or Bs=1 (GOTEJO), never both. Each tick increments elapsed time. Exit to PAUSA on the first of, in priority order: fault (-> ERRO instead), level empty, elapsed == duration on this tick, Us=0.
- PAUSA: valves closed; rest counter clears on entry and counts ticks; on the tick where it reaches T_PAUSA -> OCIOSO. Fault -> ERRO.
- ERRO: Vs=Bs=Ve=0, erro=1; held until reset (no self-recovery).
- Ve (all states except ERRO): set when level is empty or low; cleared when level is full; otherwise holds (hysteresis). Independent of session state.
- alarme = 1 whenever decoded level is empty (not in ERRO).
- ocupado = 1 in ASPERSAO, GOTEJO, PAUSA.
- BCD time: seg_u 0..9, seg_d 0..5, min_u 0..9, min_d 0..5; 59:59 wraps to 00:00. Digits hold their final value through PAUSA and OCIOSO until the next session start.

## Timing
- All outputs registered. Reset values: Vs=Bs=Ve=0, erro=0, alarme=0, ocupado=0, all BCD digits 0, state OCIOSO, counters 0.
- Start: condition true in cycle N -> state/valve asserted at N+1.
- Tick in cycle N -> digits updated at N+1. A valve is active for exactly duration ticks when no early exit occurs: the tick that makes elapsed == duration drops the valve at the next edge, and the display shows the full duration.
- Sensor conditions (fault, empty, Us=0) are evaluated every clk cycle, not just on ticks; the exit takes effect at the next edge.
- A tick without any transition in OCIOSO/ERRO is ignored. A tick coinciding with an exit condition still updates the BCD time.
- Reset mid-session closes all valves at the next edge and clears counters and erro.

## Test plan
- T_ASP=3, Ua=T=0, level full, Us=1 -> Vs high 1 cycle later for exactly 3 ticks, Bs=0, digits 00:03, then PAUSA, ocupado=1.
- T=1, Us=1, T_GOT=5; drop T to 0 after 2 ticks -> Bs stays active for all 5 ticks, Vs never asserts.
- During a session, level goes to 000 -> valve off next cycle, alarme=1, Ve=1, state PAUSA; refill to 011 keeps Ve=1, 111 clears Ve.
- T_PAUSA=2, Us held 1 -> new session starts exactly 1 cycle after the 2nd rest tick, digits cleared to 00:00.
- {H,M,L}=101 during a session -> Vs=Bs=Ve=0, erro=1; restoring 111 keeps erro=1 until reset pulse.
- Force elapsed past 59:59 (T_ASP=3599 run) -> digits read 59:59 at end; separate wrap check 59:59 -> 00:00 with a larger internal test duration is not applicable, so check digit carries at 00:09->00:10 and 00:59->01:00.
